// File: rtl/param_interval_timer_if.sv
// param_interval_timer_if: Avalon-style register bus between a host and the interval timer
interface param_interval_timer_if;
  logic        chipselect;
  logic [2:0]  address;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;
  modport master(output chipselect, address, write_n, writedata, input readdata, irq);
  modport slave(input chipselect, address, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/param_interval_timer.sv
// param_interval_timer: down-counting interval timer with one-shot/continuous modes, snapshot and level irq
module param_interval_timer #(
  parameter int          COUNT_W        = 32,
  parameter logic [31:0] RESET_PERIOD   = 32'h0000C34F,
  parameter bit          START_ON_RESET = 1'b0
) (
  input logic clk,
  input logic reset_n,
  param_interval_timer_if.slave bus
);
  localparam logic [COUNT_W-1:0] RST_P = RESET_PERIOD[COUNT_W-1:0];
  logic [COUNT_W-1:0] counter, period, snapshot;
  logic to, ito, run, cont, zero_q, force_reload;
  logic [15:0] rd_next;
  logic wr, wr_status, wr_ctrl, wr_pl, wr_ph, wr_period, wr_snap, zero, timeout;
  assign wr        = bus.chipselect & ~bus.write_n;
  assign wr_status = wr && bus.address == 3'd0;
  assign wr_ctrl   = wr && bus.address == 3'd1;
  assign wr_pl     = wr && bus.address == 3'd2;
  assign wr_ph     = wr && bus.address == 3'd3;
  assign wr_snap   = wr && (bus.address == 3'd4 || bus.address == 3'd5);
  assign wr_period = wr_pl | wr_ph;
  assign zero      = counter == '0;
  // only the transition into zero fires, so a parked zero counter stays quiet
  assign timeout   = zero & ~zero_q;
  assign bus.irq   = to & ito;
  always_comb begin
    rd_next = '0;
    case (bus.address)
      3'd0: rd_next = {14'd0, run, to};
      3'd1: rd_next = {14'd0, cont, ito};
      3'd2: rd_next = period[15:0];
      3'd3: rd_next = 16'(period[COUNT_W-1:16]);
      3'd4: rd_next = snapshot[15:0];
      3'd5: rd_next = 16'(snapshot[COUNT_W-1:16]);
      default: rd_next = '0;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter      <= RST_P;
      period       <= RST_P;
      snapshot     <= '0;
      to           <= 1'b0;
      ito          <= 1'b0;
      run          <= START_ON_RESET;
      cont         <= START_ON_RESET;
      zero_q       <= 1'b0;
      force_reload <= 1'b0;
      bus.readdata <= '0;
    end else begin
      zero_q       <= zero;
      force_reload <= wr_period;
      bus.readdata <= rd_next;
      // a period write freezes the counter; the new period lands on the next clock
      if (force_reload) counter <= period;
      else if (run && !wr_period) counter <= zero ? period : counter - COUNT_W'(1);
      if (timeout) to <= 1'b1;
      else if (wr_status) to <= 1'b0;
      if (wr_pl) period[15:0] <= bus.writedata;
      if (wr_ph) period[COUNT_W-1:16] <= bus.writedata[COUNT_W-17:0];
      if (wr_snap) snapshot <= counter;
      if (wr_ctrl) begin
        ito  <= bus.writedata[0];
        cont <= bus.writedata[1];
      end
      if (wr_period || (wr_ctrl && bus.writedata[3])) run <= 1'b0;
      else if (wr_ctrl && bus.writedata[2]) run <= 1'b1;
      else if (run && zero && !cont) run <= 1'b0;
    end
  end
endmodule

// File: tb/tb_param_interval_timer.sv
// tb_param_interval_timer: table-driven register checks plus scoreboarded multi-cycle timer scenarios
module tb_param_interval_timer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [15:0] sb_q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  param_interval_timer_if bus();
  param_interval_timer dut(.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic [2:0]  addr;
    logic        wr_en;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    bus.address = a;
    bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
  endtask

  // read with chipselect low: readdata must follow the address regardless
  task automatic rd(input logic [2:0] a, input logic [15:0] e, input string nm);
    bus.address = a;
    sb_q.push_back(e);
    @(negedge clk);
    check(nm, bus.readdata, sb_q.pop_front());
  endtask

  task automatic wait_irq(input string nm, output int at);
    int k = 0;
    while (!bus.irq && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(nm, bus.irq, 1);
    at = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t0, t1, k;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.address = 3'd0;
    bus.writedata = 16'h0;
    vecs[0]  = '{3'd0, 1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{3'd1, 1'b0, 16'h0000, 16'h0000};
    vecs[2]  = '{3'd2, 1'b0, 16'h0000, 16'hC34F};
    vecs[3]  = '{3'd3, 1'b0, 16'h0000, 16'h0000};
    vecs[4]  = '{3'd4, 1'b0, 16'h0000, 16'h0000};
    vecs[5]  = '{3'd5, 1'b0, 16'h0000, 16'h0000};
    vecs[6]  = '{3'd6, 1'b0, 16'h0000, 16'h0000};
    vecs[7]  = '{3'd7, 1'b0, 16'h0000, 16'h0000};
    vecs[8]  = '{3'd2, 1'b1, 16'h1234, 16'h1234};
    vecs[9]  = '{3'd3, 1'b1, 16'hABCD, 16'hABCD};
    vecs[10] = '{3'd1, 1'b1, 16'h000D, 16'h0001};
    vecs[11] = '{3'd0, 1'b0, 16'h0000, 16'h0000};
    vecs[12] = '{3'd6, 1'b1, 16'hFFFF, 16'h0000};
    vecs[13] = '{3'd7, 1'b1, 16'hFFFF, 16'h0000};
    vecs[14] = '{3'd1, 1'b1, 16'h0002, 16'h0002};
    vecs[15] = '{3'd2, 1'b0, 16'h0000, 16'h1234};
    idle(2);
    check("reset_readdata", bus.readdata, 0);
    check("reset_irq", bus.irq, 0);
    check("reset_counter", dut.counter, 32'h0000C34F);
    reset_n = 1'b1;
    idle(1);
    foreach (vecs[i]) begin
      if (vecs[i].wr_en) wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
    end
    // continuous mode, period 9: irq every 10 clocks, STATUS write clears it
    wr(3'd2, 16'd9);
    wr(3'd3, 16'd0);
    wr(3'd1, 16'h0007);
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      wait_irq("cont_irq", t1);
      check("cont_interval", t1 - t0, 10);
      t0 = t1;
      wr(3'd0, 16'h0);
      check("cont_clear", bus.irq, 0);
    end
    wr(3'd1, 16'h0008);
    // one-shot, period 4
    wr(3'd0, 16'h0);
    wr(3'd2, 16'd4);
    wr(3'd3, 16'd0);
    wr(3'd1, 16'h0005);
    idle(4);
    check("os_early", bus.irq, 0);
    idle(1);
    check("os_irq", bus.irq, 1);
    rd(3'd0, 16'h0001, "os_status");
    wr(3'd4, 16'h0);
    rd(3'd4, 16'h0004, "os_counter");
    wr(3'd0, 16'h0);
    idle(20);
    check("os_norefire", bus.irq, 0);
    rd(3'd0, 16'h0000, "os_status2");
    // period write mid-count
    wr(3'd2, 16'h0100);
    wr(3'd3, 16'h0000);
    wr(3'd1, 16'h0006);
    idle(5);
    wr(3'd2, 16'h0010);
    rd(3'd0, 16'h0000, "pw_status");
    check("pw_load", dut.counter, 32'h10);
    wr(3'd4, 16'h0);
    rd(3'd4, 16'h0010, "pw_counter");
    // snapshot of 0x0001_0000
    wr(3'd3, 16'h0001);
    wr(3'd2, 16'h0000);
    wr(3'd1, 16'h0006);
    wr(3'd4, 16'h0);
    rd(3'd4, 16'h0000, "snap_lo");
    rd(3'd5, 16'h0001, "snap_hi");
    idle(7);
    rd(3'd4, 16'h0000, "snap_lo_again");
    rd(3'd5, 16'h0001, "snap_hi_again");
    wr(3'd1, 16'h0008);
    // STATUS write on the timeout clock, then START+STOP together
    wr(3'd0, 16'h0);
    wr(3'd2, 16'd4);
    wr(3'd3, 16'd0);
    wr(3'd1, 16'h0005);
    idle(4);
    wr(3'd0, 16'h0);
    check("sim_to_irq", bus.irq, 1);
    rd(3'd0, 16'h0001, "sim_to_status");
    wr(3'd1, 16'h0006);
    rd(3'd0, 16'h0003, "run_on");
    wr(3'd1, 16'h000E);
    rd(3'd0, 16'h0001, "start_stop");
    check("start_stop_irq", bus.irq, 0);
    // period 0: fires once, then parks at zero
    wr(3'd0, 16'h0);
    wr(3'd3, 16'd0);
    wr(3'd2, 16'd0);
    wr(3'd1, 16'h0007);
    idle(2);
    check("zero_irq", bus.irq, 1);
    wr(3'd0, 16'h0);
    check("zero_clear", bus.irq, 0);
    idle(10);
    check("zero_norefire", bus.irq, 0);
    rd(3'd0, 16'h0002, "zero_status");
    wr(3'd1, 16'h0008);
    // asynchronous reset while counter is at 3
    wr(3'd2, 16'd4);
    wr(3'd1, 16'h0007);
    wait_irq("rst_pre_irq", t1);
    bus.address = 3'd2;
    k = 0;
    while (dut.counter != 3 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("rst_reach3", dut.counter, 3);
    #2 reset_n = 1'b0;
    #1;
    check("rst_counter", dut.counter, 32'h0000C34F);
    check("rst_irq", bus.irq, 0);
    check("rst_readdata", bus.readdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(5);
    rd(3'd0, 16'h0000, "post_rst_status");
    wr(3'd4, 16'h0);
    rd(3'd4, 16'hC34F, "post_rst_counter");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
